// File: rtl/niosii_system_sysid_checker.sv
// -----------------------------------------------------------------------------
// niosii_system_sysid_checker
//
// Avalon-MM read master that fetches the system ID peripheral (word 0 = system
// ID, word 1 = build timestamp) and compares both against build-time constants.
// A check runs automatically after reset (AUTO_START) or on a start pulse. A
// result of pass or timeout is reported with a one-cycle done pulse.
//
// Ports
//   clock, reset_n        system clock, asynchronous active-low reset
//   start                 single-cycle check request (ignored while busy)
//   avm_address/avm_read  read command (byte address, request)
//   avm_waitrequest       slave stall; command accepted when low
//   avm_readdata/valid    read response
//   busy                  check in progress
//   done                  one-cycle completion pulse
//   pass / timeout_err    result of the last check, held until the next start
//   id_value / ts_value   last captured word 0 / word 1
// -----------------------------------------------------------------------------
module niosii_system_sysid_checker #(
  parameter int unsigned ADDR_W         = 32,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h58C1_F58C,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned RETRY_MAX      = 2,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout_err,
  output logic [31:0]       id_value,
  output logic [31:0]       ts_value
);

  typedef enum logic [2:0] {
    S_IDLE, S_ID_REQ, S_ID_WAIT, S_TS_REQ, S_TS_WAIT, S_CMP, S_FAIL
  } state_t;

  localparam logic [15:0]       TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]        RTY_LAST = 3'(RETRY_MAX);
  localparam logic [ADDR_W-1:0] ID_ADDR  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] TS_ADDR  = ADDR_W'(BASE_ADDR + 32'd4);

  state_t      r_state, w_state_nx;
  logic [15:0] r_tcnt;
  logic [2:0]  r_retry;
  logic        r_first;     // high only in the first cycle after reset release
  logic        r_pass, r_tmo;
  logic [31:0] r_id, r_ts;

  logic w_req, w_wait, w_go, w_accept, w_data, w_tmo, w_retry;
  logic w_cap_id, w_cap_ts, w_cnt_clr, w_enter_fail;

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_req    = (r_state == S_ID_REQ)  || (r_state == S_TS_REQ);
    w_wait   = (r_state == S_ID_WAIT) || (r_state == S_TS_WAIT);
    w_go     = (r_state == S_IDLE) && (start || (AUTO_START && r_first));
    w_accept = w_req && !avm_waitrequest;
    // Response only counts once our command is accepted; earlier or stray
    // readdatavalid (IDLE, stalled REQ) is dropped.
    w_data   = (w_wait || w_accept) && avm_readdatavalid;
    // Data arriving in the last allowed cycle wins over the timeout.
    w_tmo    = (w_req || w_wait) && (r_tcnt == TMO_LAST) && !w_data;
    w_retry  = w_tmo && (r_retry < RTY_LAST);
    w_cap_id = w_data && ((r_state == S_ID_REQ) || (r_state == S_ID_WAIT));
    w_cap_ts = w_data && ((r_state == S_TS_REQ) || (r_state == S_TS_WAIT));
  end

  // ---------------------------------------------------------------------------
  // Next state and bus outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nx  = r_state;
    avm_read    = 1'b0;
    avm_address = ID_ADDR;
    case (r_state)
      S_IDLE: if (w_go) w_state_nx = S_ID_REQ;
      S_ID_REQ: begin
        avm_read = 1'b1;
        if (w_tmo)         w_state_nx = w_retry ? S_ID_REQ : S_FAIL;
        else if (w_accept) w_state_nx = w_data ? S_TS_REQ : S_ID_WAIT;
      end
      S_ID_WAIT: begin
        if (w_data)        w_state_nx = S_TS_REQ;
        else if (w_tmo)    w_state_nx = w_retry ? S_ID_REQ : S_FAIL;
      end
      S_TS_REQ: begin
        avm_read    = 1'b1;
        avm_address = TS_ADDR;
        if (w_tmo)         w_state_nx = w_retry ? S_TS_REQ : S_FAIL;
        else if (w_accept) w_state_nx = w_data ? S_CMP : S_TS_WAIT;
      end
      S_TS_WAIT: begin
        avm_address = TS_ADDR;
        if (w_data)        w_state_nx = S_CMP;
        else if (w_tmo)    w_state_nx = w_retry ? S_TS_REQ : S_FAIL;
      end
      S_CMP:  w_state_nx = S_IDLE;
      S_FAIL: w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Counter restarts on every (re-)entry into a REQ state.
  always_comb begin
    w_cnt_clr    = ((w_state_nx == S_ID_REQ) || (w_state_nx == S_TS_REQ)) &&
                   ((w_state_nx != r_state) || w_retry);
    w_enter_fail = (w_state_nx == S_FAIL) && (r_state != S_FAIL);
  end

  // ---------------------------------------------------------------------------
  // State, counters and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
      r_retry <= '0;
      r_first <= 1'b1;
      r_pass  <= 1'b0;
      r_tmo   <= 1'b0;
      r_id    <= '0;
      r_ts    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_first <= 1'b0;

      if (w_cnt_clr)
        r_tcnt <= '0;
      else if ((w_req || w_wait) && !w_data && !w_tmo)
        r_tcnt <= r_tcnt + 16'd1;

      // Retry budget is per word.
      if (w_go || w_cap_id) r_retry <= '0;
      else if (w_retry)     r_retry <= r_retry + 3'd1;

      if (w_cap_id) r_id <= avm_readdata;
      if (w_cap_ts) r_ts <= avm_readdata;

      if (w_go) begin
        r_pass <= 1'b0;
        r_tmo  <= 1'b0;
      end else if (w_cap_ts) begin
        // Result is ready in the CMP cycle so it is valid alongside done.
        r_pass <= (r_id == EXPECTED_ID) && (avm_readdata == EXPECTED_TS);
      end else if (w_enter_fail) begin
        r_pass <= 1'b0;
        r_tmo  <= 1'b1;
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_CMP) || (r_state == S_FAIL);
  assign pass        = r_pass;
  assign timeout_err = r_tmo;
  assign id_value    = r_id;
  assign ts_value    = r_ts;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
module tb_niosii_system_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'h58C1_F58C;
  localparam int          TMO    = 8;
  localparam int          RMAX   = 2;
  localparam logic [31:0] ID_A   = 32'h0;
  localparam logic [31:0] TS_A   = 32'h4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        waitreq = 1'b0;
  logic [31:0] rdata = '0;
  logic        rvalid = 1'b0;

  logic [31:0] d_addr, m_addr, d_id, d_ts, m_id, m_ts;
  logic        d_read, d_busy, d_done, d_pass, d_tmo;
  logic        m_read, m_busy, m_done, m_pass, m_tmo;

  always #5 clock = ~clock;

  // Main DUT (auto-start) drives the slave model.
  niosii_system_sysid_checker #(
    .ADDR_W(32), .BASE_ADDR(32'h0), .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
    .TIMEOUT_CYCLES(TMO), .RETRY_MAX(RMAX), .AUTO_START(1'b1)
  ) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(d_addr), .avm_read(d_read), .avm_waitrequest(waitreq),
    .avm_readdata(rdata), .avm_readdatavalid(rvalid),
    .busy(d_busy), .done(d_done), .pass(d_pass), .timeout_err(d_tmo),
    .id_value(d_id), .ts_value(d_ts)
  );

  // Observer copy without auto-start; only its post-reset idleness is checked.
  niosii_system_sysid_checker #(
    .ADDR_W(32), .BASE_ADDR(32'h0), .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
    .TIMEOUT_CYCLES(TMO), .RETRY_MAX(RMAX), .AUTO_START(1'b0)
  ) u_man (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(m_addr), .avm_read(m_read), .avm_waitrequest(waitreq),
    .avm_readdata(rdata), .avm_readdatavalid(rvalid),
    .busy(m_busy), .done(m_done), .pass(m_pass), .timeout_err(m_tmo),
    .id_value(m_id), .ts_value(m_ts)
  );

  int n_chk = 0, n_pass = 0;

  // ---------------- slave model ----------------
  int          ws_cfg = 0, lat_cfg = 1, ws_left = 0;
  bit          drop_id = 0;
  logic [31:0] id_data = '0, ts_data = '0;
  bit          pend = 0;
  int          pend_left = 0;
  logic [31:0] pend_dat = '0;
  bit          prev_wait = 0;
  logic [31:0] prev_addr = '0;
  int          stab_err = 0;
  logic [31:0] acc_log[$];
  int          n_done = 0, n_done_m = 0;

  initial forever begin
    @(negedge clock);
    rvalid  = 1'b0;
    waitreq = 1'b0;
    if (pend) begin
      if (pend_left == 0) begin rvalid = 1'b1; rdata = pend_dat; pend = 0; end
      else pend_left--;
    end
    if (prev_wait && (!d_read || d_addr != prev_addr)) stab_err++;
    prev_wait = 0;
    if (d_read) begin
      if (ws_left > 0) begin
        waitreq = 1'b1; ws_left--; prev_wait = 1; prev_addr = d_addr;
      end else begin
        acc_log.push_back(d_addr);
        ws_left = ws_cfg;
        if (!(d_addr == ID_A && drop_id)) begin
          if (lat_cfg == 0) begin
            rvalid = 1'b1; rdata = (d_addr == ID_A) ? id_data : ts_data;
          end else begin
            pend = 1; pend_left = lat_cfg - 1;
            pend_dat = (d_addr == ID_A) ? id_data : ts_data;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (d_done) n_done++;
    if (m_done) n_done_m++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cfg(input int ws, input int lat, input bit drop,
                     input logic [31:0] idv, input logic [31:0] tsv);
    ws_cfg = ws; ws_left = ws; lat_cfg = lat; drop_id = drop;
    id_data = idv; ts_data = tsv;
    acc_log.delete();
    stab_err = 0;
  endtask

  // Pulses start; lat = clock edges from the start-sampling edge to the edge
  // that raised done (-1 if done never came).
  task automatic run_start(output int lat);
    lat = -1;
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clock); #1;
      if (d_done) begin lat = k; break; end
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    int lat, d0;
    reset_n = 1'b0;
    cfg(0, 1, 0, EXP_ID, EXP_TS);
    repeat (3) @(posedge clock);
    #1;
    n_chk++; if ({d_read, d_busy, d_done, d_pass, d_tmo} !== 5'b0)
      $display("FAIL reset_ctl: got %b want 00000", {d_read, d_busy, d_done, d_pass, d_tmo});
    else n_pass++;
    n_chk++; if ({d_addr, d_id, d_ts} !== 96'b0)
      $display("FAIL reset_data: got %h want 0", {d_addr, d_id, d_ts}); else n_pass++;
    d0 = n_done;
    @(negedge clock); reset_n = 1'b1;
    lat = -1;
    for (int k = 0; k <= 200; k++) begin
      @(posedge clock); #1;
      if (d_done) begin lat = k; break; end
    end
    repeat (5) @(posedge clock);
    #1;
    n_chk++; if (lat !== 4) $display("FAIL auto_latency: got %0d want 4", lat); else n_pass++;
    n_chk++; if (n_done - d0 !== 1) $display("FAIL auto_done_cnt: got %0d want 1", n_done - d0); else n_pass++;
    n_chk++; if ({d_pass, d_tmo, d_busy} !== 3'b100)
      $display("FAIL auto_result: got %b want 100", {d_pass, d_tmo, d_busy}); else n_pass++;
    n_chk++; if (d_id !== EXP_ID) $display("FAIL auto_id: got %h want %h", d_id, EXP_ID); else n_pass++;
    n_chk++; if (d_ts !== EXP_TS) $display("FAIL auto_ts: got %h want %h", d_ts, EXP_TS); else n_pass++;
    n_chk++; if (!(acc_log.size() == 2 && acc_log[0] == ID_A && acc_log[1] == TS_A))
      $display("FAIL auto_addr_seq: got %0d reads want 0x0,0x4", acc_log.size()); else n_pass++;
    n_chk++; if (n_done_m !== 0) $display("FAIL man_no_autostart: got %0d want 0", n_done_m); else n_pass++;
  endtask

  task automatic test_mismatch;
    int lat;
    cfg(0, 1, 0, EXP_ID, 32'h58C1_F58D);
    run_start(lat);
    n_chk++; if (lat !== 4) $display("FAIL mm_latency: got %0d want 4", lat); else n_pass++;
    n_chk++; if ({d_pass, d_tmo} !== 2'b00) $display("FAIL mm_result: got %b want 00", {d_pass, d_tmo}); else n_pass++;
    n_chk++; if (d_ts !== 32'h58C1_F58D) $display("FAIL mm_ts: got %h want 58c1f58d", d_ts); else n_pass++;
  endtask

  task automatic test_stall;
    int lat;
    cfg(5, 1, 0, EXP_ID, EXP_TS);
    run_start(lat);
    n_chk++; if (stab_err !== 0) $display("FAIL stall_stable: got %0d want 0", stab_err); else n_pass++;
    n_chk++; if (acc_log.size() !== 2) $display("FAIL stall_reads: got %0d want 2", acc_log.size()); else n_pass++;
    n_chk++; if (lat !== 2 * (5 + 1 + 1)) $display("FAIL stall_latency: got %0d want 14", lat); else n_pass++;
    n_chk++; if (d_pass !== 1'b1) $display("FAIL stall_pass: got %b want 1", d_pass); else n_pass++;
  endtask

  task automatic test_timeout;
    int lat;
    bit all_id;
    cfg(0, 1, 1, EXP_ID, EXP_TS);
    run_start(lat);
    all_id = 1;
    foreach (acc_log[i]) if (acc_log[i] != ID_A) all_id = 0;
    n_chk++; if (acc_log.size() !== RMAX + 1 || !all_id)
      $display("FAIL tmo_reads: got %0d (all id %0d) want %0d id reads", acc_log.size(), all_id, RMAX + 1);
    else n_pass++;
    n_chk++; if (lat !== (RMAX + 1) * TMO) $display("FAIL tmo_latency: got %0d want %0d", lat, (RMAX + 1) * TMO); else n_pass++;
    repeat (4) @(posedge clock);
    #1;
    n_chk++; if ({d_tmo, d_pass, d_busy} !== 3'b100)
      $display("FAIL tmo_result: got %b want 100", {d_tmo, d_pass, d_busy}); else n_pass++;
  endtask

  // Response lands one cycle past the limit on every attempt; it must be
  // dropped when it shows up during the stalled retry request.
  task automatic test_late_data;
    int lat;
    logic [31:0] prev_id;
    prev_id = d_id;
    cfg(5, 3, 0, 32'hDEAD_BEEF, EXP_TS);
    run_start(lat);
    n_chk++; if (lat !== (RMAX + 1) * TMO) $display("FAIL late_latency: got %0d want %0d", lat, (RMAX + 1) * TMO); else n_pass++;
    n_chk++; if (d_tmo !== 1'b1) $display("FAIL late_tmo: got %b want 1", d_tmo); else n_pass++;
    n_chk++; if (d_id !== prev_id) $display("FAIL late_id_kept: got %h want %h", d_id, prev_id); else n_pass++;
  endtask

  // Data in exactly the last allowed cycle counts as success.
  task automatic test_boundary;
    int lat;
    cfg(4, 3, 0, EXP_ID, EXP_TS);
    run_start(lat);
    n_chk++; if (lat !== 2 * TMO) $display("FAIL edge_latency: got %0d want %0d", lat, 2 * TMO); else n_pass++;
    n_chk++; if ({d_pass, d_tmo} !== 2'b10) $display("FAIL edge_result: got %b want 10", {d_pass, d_tmo}); else n_pass++;
  endtask

  task automatic test_random;
    int lat, ws, lt, exp_lat;
    logic [31:0] idv, tsv;
    bit exp_pass;
    for (int it = 0; it < 16; it++) begin
      ws  = $urandom_range(0, 3);
      lt  = $urandom_range(0, 3);
      idv = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
      tsv = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
      exp_pass = (idv == EXP_ID) && (tsv == EXP_TS);
      exp_lat  = 2 * (ws + 1 + lt);
      cfg(ws, lt, 0, idv, tsv);
      run_start(lat);
      n_chk++; if (lat !== exp_lat) $display("FAIL rnd%0d_latency: got %0d want %0d", it, lat, exp_lat); else n_pass++;
      n_chk++; if ({d_pass, d_tmo} !== {exp_pass, 1'b0})
        $display("FAIL rnd%0d_result: got %b want %b0", it, {d_pass, d_tmo}, exp_pass); else n_pass++;
      n_chk++; if ({d_id, d_ts} !== {idv, tsv})
        $display("FAIL rnd%0d_values: got %h want %h", it, {d_id, d_ts}, {idv, tsv}); else n_pass++;
      n_chk++; if (!(acc_log.size() == 2 && acc_log[0] == ID_A && acc_log[1] == TS_A))
        $display("FAIL rnd%0d_addr_seq: got %0d reads want 0x0,0x4", it, acc_log.size()); else n_pass++;
    end
  endtask

  task automatic test_start_while_busy;
    int lat, d0;
    bit seen;
    cfg(0, 2, 0, EXP_ID, EXP_TS);
    d0 = n_done;
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clock); #1;
      if (d_done) begin seen = 1; break; end
    end
    start = 1'b1;                       // held through the done cycle
    @(posedge clock); #1 start = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    n_chk++; if (!seen) $display("FAIL busy_first_done: got none want 1"); else n_pass++;
    n_chk++; if (n_done - d0 !== 1) $display("FAIL busy_done_cnt: got %0d want 1", n_done - d0); else n_pass++;
    n_chk++; if ({acc_log.size() == 2, d_busy} !== 2'b10)
      $display("FAIL busy_ignored: got %0d reads busy %b want 2 reads busy 0", acc_log.size(), d_busy); else n_pass++;
    run_start(lat);
    n_chk++; if (lat !== 6) $display("FAIL busy_rerun_latency: got %0d want 6", lat); else n_pass++;
    n_chk++; if ({acc_log.size() == 4, d_pass} !== 2'b11)
      $display("FAIL busy_rerun: got %0d reads pass %b want 4 reads pass 1", acc_log.size(), d_pass); else n_pass++;
  endtask

  task automatic test_reset_abort;
    int seen, d0, dm0;
    cfg(0, 3, 0, EXP_ID, EXP_TS);
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int k = 0; k < 50 && acc_log.size() < 2; k++) begin
      @(posedge clock); #1;
    end
    n_chk++; if (acc_log.size() !== 2) $display("FAIL abort_reach_ts: got %0d reads want 2", acc_log.size()); else n_pass++;
    reset_n = 1'b0;                     // mid-cycle, during TS_WAIT
    #1;
    n_chk++; if ({d_read, d_busy, d_done, d_pass, d_tmo} !== 5'b0)
      $display("FAIL abort_ctl: got %b want 00000", {d_read, d_busy, d_done, d_pass, d_tmo}); else n_pass++;
    n_chk++; if ({d_id, d_ts} !== 64'b0) $display("FAIL abort_data: got %h want 0", {d_id, d_ts}); else n_pass++;
    // New contents; the stray in-flight response still carries EXP_TS.
    ws_cfg = 4; ws_left = 4; id_data = EXP_ID; ts_data = 32'h1234_5678;
    acc_log.delete();
    d0 = n_done; dm0 = n_done_m;
    @(posedge clock); #1 reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clock); #1;
      if (d_done) begin seen = 1; break; end
    end
    repeat (3) @(posedge clock);
    #1;
    n_chk++; if (seen !== 1) $display("FAIL abort_auto_done: got %0d want 1", seen); else n_pass++;
    n_chk++; if ({d_id, d_ts} !== {EXP_ID, 32'h1234_5678})
      $display("FAIL abort_stray_dropped: got %h want %h", {d_id, d_ts}, {EXP_ID, 32'h1234_5678}); else n_pass++;
    n_chk++; if (d_pass !== 1'b0) $display("FAIL abort_pass: got %b want 0", d_pass); else n_pass++;
    n_chk++; if ({n_done_m - dm0 == 0, m_busy, m_id, m_ts} !== {1'b1, 1'b0, 64'b0})
      $display("FAIL man_idle: got dones %0d busy %b id %h ts %h want 0", n_done_m - dm0, m_busy, m_id, m_ts);
    else n_pass++;
    n_chk++; if (n_done - d0 !== 1) $display("FAIL abort_done_cnt: got %0d want 1", n_done - d0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mismatch();
    test_stall();
    test_timeout();
    test_late_data();
    test_boundary();
    test_random();
    test_start_while_busy();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
